program_loader: RTL and testbench

Program loader for the SIMD RISC core: the write-side counterpart of the instruction fetch path. It accepts a framed word stream (header, N instruction words, checksum) over a valid/ready handshake and writes the words into instruction memory from address 0 upward. It holds the core in reset (`core_hold`) until a complete, checksum-verified image has been written. Fetch, decode, register file and ALU run only after `done`.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/loader_checksum.sv | 27 ++
 rtl/program_loader.sv | 174 +++++++++++++++++
 tb/tb_program_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame magic
// and error cause codes.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_e;

  localparam logic [15:0] LOADER_MAGIC = 16'hA5C3;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  // A session is the span in which stream words are consumed.
  function automatic logic in_session(input loader_state_e s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator over the payload words of an image; clear wins over en.
module loader_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum ^ data;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// Writes a framed image (header, N words, XOR checksum) into instruction memory
// and keeps the core held in reset until the image is complete and verified.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  loader_state_e r_state;
  loader_state_e w_next;

  logic              r_s_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_wdata;
  logic              r_core_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_len;

  logic              w_accept;
  logic              w_hdr_accept;
  logic              w_load_accept;
  logic              w_enter_hdr;
  logic [15:0]       w_hdr_magic;
  logic [15:0]       w_hdr_len;
  logic              w_len_bad;
  logic [ADDR_W:0]   w_count_inc;
  logic [DATA_W-1:0] w_sum;
  logic [1:0]        w_err_next;

  assign w_accept      = s_valid && r_s_ready;
  assign w_hdr_accept  = w_accept && (r_state == ST_HDR);
  assign w_load_accept = w_accept && (r_state == ST_LOAD);
  assign w_enter_hdr   = (w_next == ST_HDR) && (r_state != ST_HDR);
  assign w_hdr_magic   = s_data[31:16];
  assign w_hdr_len     = s_data[15:0];
  assign w_len_bad     = (w_hdr_len == 16'd0) || (32'(w_hdr_len) > DEPTH);
  assign w_count_inc   = r_count + {{ADDR_W{1'b0}}, 1'b1};

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (w_enter_hdr),
    .en    (w_load_accept),
    .data  (s_data),
    .sum   (w_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_next = ERR_NONE;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (w_accept) begin
          if (w_hdr_magic != LOADER_MAGIC) begin
            w_next     = ST_ERROR;
            w_err_next = ERR_MAGIC;
          end else if (w_len_bad) begin
            w_next     = ST_ERROR;
            w_err_next = ERR_LEN;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_accept && (w_count_inc == r_len)) w_next = ST_CHK;
      end
      ST_CHK: begin
        if (w_accept) begin
          if (s_data == w_sum) begin
            w_next = ST_DONE;
          end else begin
            w_next     = ST_ERROR;
            w_err_next = ERR_CSUM;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_ready    <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_hold  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_count      <= '0;
      r_len        <= '0;
    end else begin
      r_s_ready   <= in_session(w_next);
      r_busy      <= in_session(w_next);
      r_done      <= (w_next == ST_DONE);
      r_error     <= (w_next == ST_ERROR);
      r_core_hold <= (w_next != ST_DONE);
      r_imem_we   <= w_load_accept;

      if (w_load_accept) begin
        r_imem_addr  <= r_count[ADDR_W-1:0];
        r_imem_wdata <= s_data;
      end

      if (w_enter_hdr) begin
        r_count <= '0;
      end else if (w_load_accept) begin
        r_count <= w_count_inc;
      end

      if (w_enter_hdr) begin
        r_len <= '0;
      end else if (w_hdr_accept && (w_next == ST_LOAD)) begin
        r_len <= w_hdr_len[ADDR_W:0];
      end

      // Cause is latched on entry to ERROR and dropped as soon as ERROR is left.
      if (w_next != ST_ERROR) begin
        r_err_code <= ERR_NONE;
      end else if (r_state != ST_ERROR) begin
        r_err_code <= w_err_next;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_hold  = r_core_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: framing, errors, full depth,
// stalls, ignored start/valid and asynchronous reset mid-session.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  wrAddr[$];
  logic [31:0] wrData[$];
  logic [31:0] imgWords[$];

  program_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every memory write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    int waitCnt;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    s_valid = 1'b1;
    s_data  = w;
    waitCnt = 0;
    while (s_ready !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout word=%h s_ready=%b required=1", w, s_ready);
    end else begin
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Sends header, imgWords and their XOR; optional stalls and a start pulse mid-payload.
  task automatic sendImage(input bit withGaps, input bit midStart);
    logic [31:0] sum;
    sum = 32'h0;
    sendWord({16'hA5C3, 16'(imgWords.size())}, 0);
    for (int i = 0; i < imgWords.size(); i++) begin
      if (midStart && i == imgWords.size() / 2) begin
        s_valid = 1'b0;
        pulseStart();
      end
      sendWord(imgWords[i], withGaps ? (i * 7) % 3 : 0);
      sum = sum ^ imgWords[i];
    end
    sendWord(sum, 0);
  endtask

  task automatic test_reset();
    logic [47:0] obs;
    reset = 1'b0;
    tick();
    tick();
    obs = {s_ready, imem_we, busy, done, error, core_hold, err_code, imem_addr, imem_wdata};
    checks++;
    if (obs !== {5'b00000, 1'b1, 2'b00, 8'h00, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h required=%h", obs, {5'b00000, 1'b1, 2'b00, 8'h00, 32'h0});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b0 || core_hold !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_after_reset s_ready=%b core_hold=%b required 0/1", s_ready, core_hold);
    end
  endtask

  task automatic test_basic_load();
    wrAddr.delete();
    wrData.delete();
    pulseStart();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_to_ready s_ready=%b busy=%b required 1/1", s_ready, busy);
    end
    sendWord(32'hA5C30003, 0);
    sendWord(32'h00000001, 0);
    sendWord(32'h00000002, 0);
    sendWord(32'h00000003, 0);
    checks++;
    if (imem_we !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL last_write_before_release we=%b hold=%b done=%b required 1/1/0", imem_we, core_hold, done);
    end
    sendWord(32'h00000000, 0);
    checks++;
    if (done !== 1'b1 || core_hold !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done done=%b hold=%b busy=%b ready=%b required 1/0/0/0", done, core_hold, busy, s_ready);
    end
    tick();
    checks++;
    if (wrAddr.size() != 3) begin
      failures++;
      $display("[TB] FAIL basic_write_count got=%0d required=3", wrAddr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wrAddr[i] !== 8'(i) || wrData[i] !== 32'(i + 1)) begin
          failures++;
          $display("[TB] FAIL basic_write%0d addr=%h data=%h required %h/%h", i, wrAddr[i], wrData[i], 8'(i), 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_idle_valid();
    wrAddr.delete();
    s_valid = 1'b1;
    s_data  = 32'hA5C30001;
    tick();
    tick();
    tick();
    s_valid = 1'b0;
    checks++;
    if (wrAddr.size() != 0 || s_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL valid_in_done writes=%0d ready=%b done=%b busy=%b required 0/0/1/0", wrAddr.size(), s_ready, done, busy);
    end
  endtask

  task automatic test_bad_magic();
    wrAddr.delete();
    pulseStart();
    checks++;
    if (core_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL leave_done hold=%b done=%b busy=%b required 1/0/1", core_hold, done, busy);
    end
    sendWord(32'h12340003, 0);
    tick();
    checks++;
    if (error !== 1'b1 || err_code !== 2'b01 || core_hold !== 1'b1 || busy !== 1'b0 || wrAddr.size() != 0) begin
      failures++;
      $display("[TB] FAIL bad_magic err=%b code=%b hold=%b busy=%b writes=%0d required 1/01/1/0/0", error, err_code, core_hold, busy, wrAddr.size());
    end
  endtask

  task automatic test_bad_length();
    pulseStart();
    checks++;
    if (error !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("[TB] FAIL leave_error err=%b code=%b required 0/00", error, err_code);
    end
    sendWord(32'hA5C30000, 0);
    checks++;
    if (error !== 1'b1 || err_code !== 2'b10) begin
      failures++;
      $display("[TB] FAIL len_zero err=%b code=%b required 1/10", error, err_code);
    end
    pulseStart();
    sendWord(32'hA5C30101, 0);
    checks++;
    if (error !== 1'b1 || err_code !== 2'b10 || core_hold !== 1'b1) begin
      failures++;
      $display("[TB] FAIL len_257 err=%b code=%b hold=%b required 1/10/1", error, err_code, core_hold);
    end
  endtask

  task automatic test_full_depth();
    int bad;
    wrAddr.delete();
    wrData.delete();
    imgWords.delete();
    for (int i = 0; i < 256; i++) imgWords.push_back((32'(i) * 32'h01010101) ^ 32'h5A000000);
    pulseStart();
    sendImage(1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_done done=%b hold=%b err=%b required 1/0/0", done, core_hold, error);
    end
    tick();
    checks++;
    if (wrAddr.size() != 256) begin
      failures++;
      $display("[TB] FAIL full_write_count got=%0d required=256", wrAddr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wrAddr[i] !== 8'(i) || wrData[i] !== imgWords[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL full_write_contents bad_entries=%0d required=0", bad);
      end
      checks++;
      if (wrAddr[255] !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL full_last_addr got=%h required=ff", wrAddr[255]);
      end
    end
  endtask

  task automatic test_checksum_recovery();
    wrAddr.delete();
    pulseStart();
    sendWord(32'hA5C30001, 0);
    sendWord(32'hDEADBEEF, 0);
    sendWord(32'h00000000, 0);
    checks++;
    if (error !== 1'b1 || err_code !== 2'b11 || core_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL csum_mismatch err=%b code=%b hold=%b done=%b required 1/11/1/0", error, err_code, core_hold, done);
    end
    imgWords.delete();
    imgWords.push_back(32'h12345678);
    imgWords.push_back(32'h0F0F0F0F);
    pulseStart();
    sendImage(1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || err_code !== 2'b00 || core_hold !== 1'b0) begin
      failures++;
      $display("[TB] FAIL csum_recovery done=%b err=%b code=%b hold=%b required 1/0/00/0", done, error, err_code, core_hold);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    wrAddr.delete();
    wrData.delete();
    imgWords.delete();
    for (int i = 0; i < 16; i++) imgWords.push_back(32'hC0DE0000 + 32'(i * 17));
    pulseStart();
    sendImage(1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_done done=%b err=%b required 1/0", done, error);
    end
    tick();
    checks++;
    if (wrAddr.size() != 16) begin
      failures++;
      $display("[TB] FAIL stall_write_count got=%0d required=16", wrAddr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (wrAddr[i] !== 8'(i) || wrData[i] !== imgWords[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL stall_write_order bad_entries=%0d required=0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_session();
    logic [47:0] obs;
    pulseStart();
    sendWord(32'hA5C30008, 0);
    for (int i = 0; i < 5; i++) sendWord(32'hAAAA0000 + 32'(i), 0);
    reset = 1'b0;
    #1;
    obs = {s_ready, imem_we, busy, done, error, core_hold, err_code, imem_addr, imem_wdata};
    checks++;
    if (obs !== {5'b00000, 1'b1, 2'b00, 8'h00, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_mid_session got=%h required=%h", obs, {5'b00000, 1'b1, 2'b00, 8'h00, 32'h0});
    end
    tick();
    reset = 1'b1;
    tick();
    wrAddr.delete();
    wrData.delete();
    imgWords.delete();
    imgWords.push_back(32'h11111111);
    imgWords.push_back(32'h22222222);
    imgWords.push_back(32'h44444444);
    imgWords.push_back(32'h88888888);
    pulseStart();
    sendImage(1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || core_hold !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_done done=%b hold=%b required 1/0", done, core_hold);
    end
    tick();
    checks++;
    if (wrAddr.size() != 4 || wrAddr[0] !== 8'h00 || wrAddr[3] !== 8'h03 || wrData[3] !== 32'h88888888) begin
      failures++;
      $display("[TB] FAIL post_reset_writes count=%0d a0=%h a3=%h d3=%h required 4/00/03/88888888",
               wrAddr.size(), wrAddr[0], wrAddr[3], wrData[3]);
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    test_reset();
    test_basic_load();
    test_idle_valid();
    test_bad_magic();
    test_bad_length();
    test_full_depth();
    test_checksum_recovery();
    test_backpressure();
    test_reset_mid_session();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
